// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer for a slot-partitioned instruction ROM.
// Optional quantum preemption timer is enabled with `define PREEMPT_TIMER_EN.
module pc_fetch_unit #(
  parameter int ADDR_WIDTH      = 13,
  parameter int SLOT_BITS       = 2,
  parameter int SLOT_WORDS_LOG2 = 9,
  parameter int QUANTUM         = 256
) (
  input  logic                       Fast_Clock,
  input  logic                       Reset,
  input  logic                       Stall,
  input  logic                       Halt,
  input  logic                       Resume,
  input  logic                       Jump_En,
  input  logic [SLOT_WORDS_LOG2-1:0] Jump_Target,
  input  logic                       Trap,
  input  logic                       Switch_Req,
  input  logic [SLOT_BITS-1:0]       Switch_Slot,
  output logic [ADDR_WIDTH-1:0]      PC,
  output logic                       Instr_Valid,
  output logic [SLOT_BITS-1:0]       Cur_Slot,
  output logic                       Preempt
);

  // state     | meaning
  // ST_RUN    | fetching; PC advances unless stalled or redirected
  // ST_HALTED | PC frozen, no valid instructions until Resume or Switch_Req
  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  localparam int PAD    = ADDR_WIDTH - SLOT_BITS - SLOT_WORDS_LOG2;
  localparam int NSLOTS = 1 << SLOT_BITS;

  state_t                     state_q, state_d;
  logic [SLOT_WORDS_LOG2-1:0] lpc_q, lpc_d;
  logic [SLOT_BITS-1:0]       slot_q, slot_d;
  logic                       valid_q, valid_d;
  logic [SLOT_WORDS_LOG2-1:0] tbl_q [NSLOTS];
  logic                       tbl_we;
  logic                       preempt_int;
  logic                       do_trap;
  logic                       do_switch;

  always_comb begin
    state_d   = state_q;
    lpc_d     = lpc_q;
    slot_d    = slot_q;
    valid_d   = valid_q;
    tbl_we    = 1'b0;
    do_trap   = (state_q == ST_RUN) && (Trap || preempt_int) && (slot_q != '0);
    do_switch = !do_trap && Switch_Req;

    if (do_trap) begin
      tbl_we  = 1'b1;
      slot_d  = '0;
      lpc_d   = '0;
      valid_d = 1'b0;
    end else if (do_switch) begin
      // Same-slot switch reloads the PC being saved: one-bubble restart.
      tbl_we  = 1'b1;
      slot_d  = Switch_Slot;
      lpc_d   = (Switch_Slot == slot_q) ? lpc_q : tbl_q[Switch_Slot];
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (state_q == ST_HALTED) begin
      valid_d = 1'b0;
      if (Resume) state_d = ST_RUN;
    end else if (Halt) begin
      state_d = ST_HALTED;
      valid_d = 1'b0;
    end else if (Jump_En) begin
      lpc_d   = Jump_Target;
      valid_d = 1'b0;
    end else if (!Stall) begin
      lpc_d   = lpc_q + 1'b1;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_RUN;
      lpc_q   <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lpc_q   <= lpc_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NSLOTS; i++) tbl_q[i] <= '0;
    end else if (tbl_we) begin
      tbl_q[slot_q] <= lpc_q;
    end
  end

`ifdef PREEMPT_TIMER_EN
  localparam int CW = $clog2(QUANTUM) + 1;

  logic [CW-1:0] cnt_q;
  logic          preempt_q;

  assign preempt_int = (state_q == ST_RUN) && (slot_q != '0) &&
                       (cnt_q == CW'(QUANTUM - 1));

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= preempt_int && !Trap;
      if (slot_d != slot_q)
        cnt_q <= '0;
      else if ((state_q == ST_RUN) && (slot_q != '0) && !Stall)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign Preempt = preempt_q;
`else
  logic unused_quantum;
  assign unused_quantum = (QUANTUM > 0);
  assign preempt_int    = 1'b0;
  assign Preempt        = 1'b0;
`endif

  assign PC          = {{PAD{1'b0}}, slot_q, lpc_q};
  assign Cur_Slot    = slot_q;
  assign Instr_Valid = valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized and directed bench for pc_fetch_unit against a behavioural model.
module tb_pc_fetch_unit;
  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0, halt = 1'b0, resume = 1'b0, jump = 1'b0;
  logic [8:0] jt = '0;
  logic       trap = 1'b0, sw = 1'b0;
  logic [1:0] ss = '0;
  logic [12:0] PC;
  logic       Instr_Valid;
  logic [1:0] Cur_Slot;
  logic       Preempt;

  int total = 0;
  int bad   = 0;

  // model state
  int m_slot, m_lpc, m_valid, m_halt, m_pre, m_cnt;
  int m_tab [4];
  int ns;
  bit expire, trap_go, inc;

  pc_fetch_unit #(.QUANTUM(Q)) dut (
    .Fast_Clock(clk), .Reset(rst), .Stall(stall), .Halt(halt), .Resume(resume),
    .Jump_En(jump), .Jump_Target(jt), .Trap(trap), .Switch_Req(sw),
    .Switch_Slot(ss), .PC(PC), .Instr_Valid(Instr_Valid), .Cur_Slot(Cur_Slot),
    .Preempt(Preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_slot = 0; m_lpc = 0; m_valid = 0; m_halt = 0; m_pre = 0; m_cnt = 0;
      for (int i = 0; i < 4; i++) m_tab[i] = 0;
    end else begin
      expire = 1'b0;
`ifdef PREEMPT_TIMER_EN
      expire = (m_halt == 0) && (m_slot != 0) && (m_cnt == Q - 1);
`endif
      trap_go = (m_halt == 0) && (m_slot != 0) && (trap || expire);
      m_pre   = (expire && !trap) ? 1 : 0;
      inc     = (m_halt == 0) && (m_slot != 0) && !stall;
      ns      = m_slot;
      if (trap_go) begin
        m_tab[m_slot] = m_lpc; ns = 0; m_lpc = 0; m_valid = 0;
      end else if (sw) begin
        m_tab[m_slot] = m_lpc; ns = int'(ss); m_lpc = m_tab[ns];
        m_valid = 0; m_halt = 0;
      end else if (m_halt != 0) begin
        m_valid = 0;
        if (resume) m_halt = 0;
      end else if (halt) begin
        m_halt = 1; m_valid = 0;
      end else if (jump) begin
        m_lpc = int'(jt); m_valid = 0;
      end else if (!stall) begin
        m_lpc = (m_lpc + 1) % 512; m_valid = 1;
      end
      if (ns != m_slot) m_cnt = 0;
      else if (inc) m_cnt = m_cnt + 1;
      m_slot = ns;
    end
  end

  always @(negedge clk) begin
    chk("model_pc", int'(PC), m_slot * 512 + m_lpc);
    chk("model_valid", int'(Instr_Valid), m_valid);
    chk("model_slot", int'(Cur_Slot), m_slot);
    chk("model_preempt", int'(Preempt), m_pre);
  end

  task automatic drive(input bit st, input bit hl, input bit rs, input bit je,
                       input int tgt, input bit tr, input bit sr, input int sl);
    stall = st; halt = hl; resume = rs; jump = je; jt = 9'(tgt);
    trap = tr; sw = sr; ss = 2'(sl);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic pin(input string nm, input int pc, input int v, input int sl);
    chk({nm, "_pc"}, int'(PC), pc);
    chk({nm, "_valid"}, int'(Instr_Valid), v);
    chk({nm, "_slot"}, int'(Cur_Slot), sl);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pin("reset", 0, 0, 0);
    chk("reset_preempt", int'(Preempt), 0);

    for (int i = 1; i <= 5; i++) begin
      idle_step();
      pin("free_run", i, 1, 0);
    end
    idle_step(); idle_step();
    chk("at7", int'(PC), 7);

    drive(0, 0, 0, 0, 0, 0, 1, 2); step();
    pin("sw2", 1024, 0, 2);
    idle_step();
    pin("sw2_run", 1025, 1, 2);
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    pin("back0", 7, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 2); step();
    pin("resume2", 1025, 0, 2);
    drive(0, 0, 0, 1, 40, 0, 0, 0); step();
    pin("jump40", 1064, 0, 2);
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    pin("trap", 0, 0, 0);
    idle_step();
    drive(0, 0, 0, 0, 0, 0, 1, 2); step();
    pin("retrap", 1064, 0, 2);
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    pin("trap2", 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 1, 3); step();
    pin("sw3", 1536, 0, 3);
    drive(0, 0, 0, 1, 510, 0, 0, 0); step();
    pin("j510", 2046, 0, 3);
    idle_step();
    pin("at511", 2047, 1, 3);
    idle_step();
    pin("wrap", 1536, 1, 3);
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    pin("trap3", 0, 0, 0);
    chk("trap3_preempt", int'(Preempt), 0);

    idle_step();
    drive(0, 1, 0, 0, 0, 0, 0, 0); step();
    pin("halt", 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0); step();
    pin("halt_stall", 1, 0, 0);
    drive(0, 0, 0, 1, 99, 0, 0, 0); step();
    pin("halt_jump", 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    pin("halt_trap", 1, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0); step();
    pin("resume", 1, 0, 0);
    idle_step();
    pin("after_resume", 2, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    pin("trap_os_ignored", 3, 1, 0);

`ifdef PREEMPT_TIMER_EN
    drive(0, 0, 0, 0, 0, 0, 1, 1); step();
    pin("sw1", 512, 0, 1);
    idle_step();
    drive(1, 0, 0, 0, 0, 0, 0, 0); step();
    idle_step(); idle_step();
    chk("pre_expiry_preempt", int'(Preempt), 0);
    idle_step();
    pin("preempt", 0, 0, 0);
    chk("preempt_pulse", int'(Preempt), 1);
    idle_step();
    chk("preempt_drop", int'(Preempt), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1); step();
    pin("saved1", 515, 0, 1);
    idle_step(); idle_step(); idle_step();
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    pin("trap_expiry", 0, 0, 0);
    chk("trap_expiry_preempt", int'(Preempt), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1); step();
    pin("saved1b", 518, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
`endif

    drive(0, 0, 0, 0, 0, 0, 1, 1); step();
    drive(0, 0, 0, 1, 77, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    idle_step();
    #3 rst = 1'b1;
    #1 pin("async_reset", 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 1); step();
    pin("table_cleared", 512, 0, 1);

    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
            int'($urandom_range(0, 511)), $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 4, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 999) < 2) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
